key_debounce_module: RTL and testbench
======================================

Name: key_debounce_module

Overview:
- Debounces a raw, bouncy active-low key line, such as the virtual-key bounce generator output or a physical key pin.
- Produces a clean level plus single-cycle press/release strobes for downstream control logic.
- Reports how many edges were seen before each decision, so bench and board can check the filter against the generated bounce.
- Sits directly downstream of the bounce source; one 20 MHz clock domain.

Parameters:
T_STABLE, 18'd200000, cycles the synchronized input must hold a level to be accepted (10 ms at 20 MHz); legal range 2..262143
CNT_W, 18, width of the stability counter; must hold T_STABLE-1

Ports:
clk  input  1  system clock, 20 MHz
rst_n  input  1  asynchronous active-low reset
in_sig  input  1  raw key line, idle high, pressed low, asynchronous to clk
key_level  output  1  debounced level: 1 released, 0 pressed
press_pulse  output  1  one-cycle strobe on accepted press
release_pulse  output  1  one-cycle strobe on accepted release
bounce_cnt  output  4  edges counted during the last completed filter window, saturating at 15

Behaviour:
- Reset values:
  - Sync flops f1, f2, f3 = 1.
  - key_level = 1; press_pulse = release_pulse = 0; bounce_cnt = 0.
  - Counter = 0; state = IDLE_UP.
- Input path:
  - f1 <= in_sig; f2 <= f1; f3 <= f2.
  - edge = (f2 != f3). Only f2 and edge feed the FSM.
- States:
  - IDLE_UP: released.
  - FILT_DN: judging a possible press.
  - IDLE_DN: pressed.
  - FILT_UP: judging a possible release.
- IDLE_UP:
  - On edge: go to FILT_DN, cnt <= 0, ecnt <= 1.
  - Otherwise hold.
- FILT_DN:
  - On edge: cnt <= 0, ecnt <= sat(ecnt+1).
  - Else if cnt == T_STABLE-1: decide.
    - f2 == 0: go to IDLE_DN, key_level <= 0, press_pulse <= 1, bounce_cnt <= ecnt.
    - f2 == 1 (glitch rejected): go to IDLE_UP, no pulse, bounce_cnt <= ecnt.
  - Else cnt <= cnt+1.
- IDLE_DN and FILT_UP mirror IDLE_UP and FILT_DN with levels inverted:
  - Acceptance: key_level <= 1, release_pulse <= 1.
  - Glitch: return to IDLE_DN.
- Timing: the decision takes effect T_STABLE+2 clock edges after the edge at which f1 captured the final level of in_sig. A new edge at any point restarts the full window.
- Pulses:
  - Registered; high exactly one cycle, coincident with the key_level change.
  - press_pulse and release_pulse are never high together.
  - No pulse fires on reset release or on a rejected glitch.
- ecnt:
  - 4-bit internal edge counter, saturating at 15.
  - bounce_cnt updates only at a decision and holds between decisions.
- Edge and decision in the same cycle: the edge wins (counter restarts, no decision).
- rst_n asserted mid-filter: all state returns to reset values immediately. After release, the FSM starts in IDLE_UP regardless of in_sig. If in_sig is low, f2/f3 are preset high, so an edge is seen and a normal press filter follows.
- Counter never exceeds T_STABLE-1; no wrap-around is possible.

Decomposition:
- Shared package key_pkg:
  - FSM state encoding (IDLE_UP, FILT_DN, IDLE_DN, FILT_UP, 2-bit).
  - Clock constants: CLK_HZ = 20_000_000; T10MS = 200000, shared with the bounce generator's T8MS = 160000.
  - Saturation max for bounce_cnt.
- Optional sub-module key_sync_module: 3-flop synchronizer plus edge detect, reset to 1, outputs f2 and edge. The reused bounce generator can share it.

Test Plan (T_STABLE = 16 for simulation):
1. Reset with in_sig = 1 held 100 cycles -> key_level = 1, no pulses, bounce_cnt = 0 throughout.
2. Clean press: in_sig 1->0 held -> press_pulse high exactly 1 cycle, 18 edges after the f1 capture; key_level = 0 the same cycle; bounce_cnt = 1.
3. Bouncy press: in_sig 0,1,0,1,0 (3 cycles each), then 0 held -> exactly one press_pulse, 18 edges after the last fall; bounce_cnt = 5. Repeat using the virtual-key generator output (6 bounces plus the clean edge) -> one press_pulse, bounce_cnt = 7.
4. Glitch: in_sig low for 5 cycles, then high held -> no press_pulse; key_level stays 1; state returns to IDLE_UP; bounce_cnt = 2.
5. Bouncy release from pressed: 1,0,1 (2 cycles each), then 1 held -> one release_pulse, key_level = 1, bounce_cnt = 3. Then 20 alternating edges -> bounce_cnt saturates at 15.
6. Reset mid-FILT_DN (cnt = 8): rst_n low for 2 cycles with in_sig low -> all outputs at reset values; after release, press accepted T_STABLE+2 cycles later with one press_pulse.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the key debounce filter and the bounce generator.
package key_pkg;

  // Filter FSM encoding: two idle levels and two judging windows.
  typedef enum logic [1:0] {
    IDLE_UP = 2'd0,
    FILT_DN = 2'd1,
    IDLE_DN = 2'd2,
    FILT_UP = 2'd3
  } key_state_e;

  // Clock and timing constants (20 MHz system clock).
  localparam int unsigned CLK_HZ = 20_000_000;
  localparam int unsigned T10MS  = 200000;
  localparam int unsigned T8MS   = 160000;

  // The edge count reported downstream saturates here.
  localparam logic [3:0] ECNT_MAX = 4'd15;

  // Saturating increment for the 4-bit edge counter.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == ECNT_MAX) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/key_sync_module.sv
// Three-flop synchronizer with edge detect on the synchronized level.
// Flops preset to 1 (released) so a key held low through reset still
// produces an edge once reset is released.
module key_sync_module (
  input  logic clk,
  input  logic rst_n,
  input  logic in_sig,
  output logic sync_lvl,
  output logic edge_seen
);

  logic f1;
  logic f2;
  logic f3;

  // Shift the raw line through three flops; f1/f2 settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f1 <= 1'b1;
      f2 <= 1'b1;
      f3 <= 1'b1;
    end else begin
      f1 <= in_sig;
      f2 <= f1;
      f3 <= f2;
    end
  end

  assign sync_lvl  = f2;
  assign edge_seen = f2 ^ f3;

endmodule

// File: rtl/key_debounce_module.sv
// Debounce filter for an active-low key: clean level, press/release
// strobes and a count of edges seen inside each completed window.
// Any edge inside a window restarts the full stability count; the
// window closes after T_STABLE quiet cycles and accepts the level only
// if it differs from the current debounced level.
module key_debounce_module
  import key_pkg::*;
#(
  parameter int unsigned T_STABLE = T10MS,
  parameter int unsigned CNT_W    = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_sig,
  output logic       key_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [3:0] bounce_cnt,
  output key_state_e dbg_state
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T_STABLE - 1);

  logic             f2;
  logic             edge_seen;
  key_state_e       state;
  key_state_e       state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [3:0]       ecnt;
  logic [3:0]       ecnt_n;
  logic             level_n;
  logic             press_n;
  logic             release_n;
  logic [3:0]       bounce_n;

  key_sync_module u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_sig    (in_sig),
    .sync_lvl  (f2),
    .edge_seen (edge_seen)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE_UP;
      cnt           <= '0;
      ecnt          <= '0;
      key_level     <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      bounce_cnt    <= '0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      ecnt          <= ecnt_n;
      key_level     <= level_n;
      press_pulse   <= press_n;
      release_pulse <= release_n;
      bounce_cnt    <= bounce_n;
    end
  end

  // Next-state logic; an edge always beats a decision in the same cycle.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ecnt_n    = ecnt;
    level_n   = key_level;
    press_n   = 1'b0;
    release_n = 1'b0;
    bounce_n  = bounce_cnt;
    case (state)
      IDLE_UP, IDLE_DN: begin
        if (edge_seen) begin
          state_n = (state == IDLE_UP) ? FILT_DN : FILT_UP;
          cnt_n   = '0;
          ecnt_n  = 4'd1;
        end
      end
      FILT_DN, FILT_UP: begin
        if (edge_seen) begin
          cnt_n  = '0;
          ecnt_n = sat_inc(ecnt);
        end else if (cnt == CNT_LAST) begin
          bounce_n = ecnt;
          if (state == FILT_DN) begin
            if (!f2) begin
              state_n = IDLE_DN;
              level_n = 1'b0;
              press_n = 1'b1;
            end else begin
              state_n = IDLE_UP;
            end
          end else begin
            if (f2) begin
              state_n   = IDLE_UP;
              level_n   = 1'b1;
              release_n = 1'b1;
            end else begin
              state_n = IDLE_DN;
            end
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE_UP;
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_key_debounce_module.sv
// Bench for key_debounce_module with a short stability window.
module tb_key_debounce_module;
  import key_pkg::*;

  localparam int TS = 16;
  localparam int W  = 9;
  localparam int HN = 16384;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_sig = 1'b1;
  logic       key_level;
  logic       press_pulse;
  logic       release_pulse;
  logic [3:0] bounce_cnt;
  key_state_e dbg_state;

  always #25 clk = ~clk;

  key_debounce_module #(.T_STABLE(TS), .CNT_W(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_sig        (in_sig),
    .key_level     (key_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .bounce_cnt    (bounce_cnt),
    .dbg_state     (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Timestamp model: every clock the key line is sampled into a history
  // array; the filter sees each sample two clocks late. A window opens at
  // the first change, every later change restarts it, and it closes TS
  // clocks after the last change with the level then seen.
  typedef struct packed {
    logic       level;
    logic       press;
    logic       rel;
    logic [3:0] bounce;
    logic       open;
    int         ecnt;
    int         last;
  } model_t;

  localparam model_t MODEL_RST = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 0, 0};

  model_t m;
  logic   hist [0:HN-1];
  int     n_s;

  function automatic logic samp(input int i);
    return (i < 0) ? 1'b1 : hist[i % HN];
  endfunction

  function automatic model_t model_step(input model_t s, input int n, input logic cur, input logic prev);
    model_t r = s;
    r.press = 1'b0;
    r.rel   = 1'b0;
    if (cur != prev) begin
      r.ecnt = s.open ? ((s.ecnt < 15) ? s.ecnt + 1 : 15) : 1;
      r.open = 1'b1;
      r.last = n;
    end else if (s.open && (n - s.last == TS)) begin
      r.open   = 1'b0;
      r.bounce = 4'(s.ecnt);
      if (cur != s.level) begin
        r.level = cur;
        r.press = ~cur;
        r.rel   = cur;
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] pack(input model_t s);
    key_state_e st;
    st = s.open ? (s.level ? FILT_DN : FILT_UP) : (s.level ? IDLE_UP : IDLE_DN);
    return {st, s.level, s.press, s.rel, s.bounce};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m   <= MODEL_RST;
      n_s <= 0;
      exp_q.delete();
    end else begin
      hist[n_s % HN] <= in_sig;
      exp_q.push_back(pack(model_step(m, n_s, samp(n_s - 2), samp(n_s - 3))));
      m   <= model_step(m, n_s, samp(n_s - 2), samp(n_s - 3));
      n_s <= n_s + 1;
    end
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0)
      check("scoreboard", int'({dbg_state, key_level, press_pulse, release_pulse, bounce_cnt}),
            int'(exp_q.pop_front()));
    else
      check("scoreboard_rst", int'({dbg_state, key_level, press_pulse, release_pulse, bounce_cnt}),
            int'(pack(MODEL_RST)));
  end

  // ---------------- driver tasks ----------------
  task automatic apply(input logic v, input int cycles, output int np, output int nr);
    np = 0;
    nr = 0;
    in_sig = v;
    repeat (cycles) begin
      @(negedge clk);
      np += int'(press_pulse);
      nr += int'(release_pulse);
    end
  endtask

  task automatic wait_press(output int lat, output logic lvl_at);
    lat    = -1;
    lvl_at = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (press_pulse) begin
        lat    = k - 1;
        lvl_at = key_level;
        break;
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic v;
    int   cyc;
    logic lvl;
    int   bnc;
    int   np;
    int   nr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic v, input int cyc, input logic lvl,
                              input int bnc, input int np, input int nr);
    vecs.push_back('{v, cyc, lvl, bnc, np, nr});
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   np;
    int   nr;
    int   lat;
    logic lvl_at;
    int   vk_w [6];
    vk_w = '{2, 4, 3, 5, 2, 6};

    // idle, clean press and release
    add(1'b1, 100, 1'b1, 0, 0, 0);
    add(1'b0, 40, 1'b0, 1, 1, 0);
    add(1'b1, 40, 1'b1, 1, 0, 1);
    // bouncy press 0,1,0,1,0
    add(1'b0, 3, 1'b1, 1, 0, 0);
    add(1'b1, 3, 1'b1, 1, 0, 0);
    add(1'b0, 3, 1'b1, 1, 0, 0);
    add(1'b1, 3, 1'b1, 1, 0, 0);
    add(1'b0, 40, 1'b0, 5, 1, 0);
    add(1'b1, 40, 1'b1, 1, 0, 1);
    // virtual-key style: 6 bounces plus the clean edge
    for (int i = 0; i < 6; i++) add(logic'(i % 2), vk_w[i], 1'b1, 1, 0, 0);
    add(1'b0, 40, 1'b0, 7, 1, 0);
    add(1'b1, 40, 1'b1, 1, 0, 1);
    // glitch rejected
    add(1'b0, 5, 1'b1, 1, 0, 0);
    add(1'b1, 40, 1'b1, 2, 0, 0);
    // bouncy release from pressed
    add(1'b0, 40, 1'b0, 1, 1, 0);
    add(1'b1, 2, 1'b0, 1, 0, 0);
    add(1'b0, 2, 1'b0, 1, 0, 0);
    add(1'b1, 40, 1'b1, 3, 0, 1);
    // 20 alternating edges: counter saturates, glitch back to released
    for (int i = 0; i < 20; i++) add(logic'(i % 2), 2, 1'b1, 3, 0, 0);
    add(1'b1, 40, 1'b1, 15, 0, 0);

    #1 rst_n = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      apply(vecs[i].v, vecs[i].cyc, np, nr);
      check($sformatf("row%0d_level", i), int'(key_level), int'(vecs[i].lvl));
      check($sformatf("row%0d_bounce", i), int'(bounce_cnt), vecs[i].bnc);
      check($sformatf("row%0d_press", i), np, vecs[i].np);
      check($sformatf("row%0d_release", i), nr, vecs[i].nr);
    end
    check("glitch_state", int'(dbg_state), int'(IDLE_UP));

    // exact press latency and pulse width
    in_sig = 1'b0;
    wait_press(lat, lvl_at);
    check("press_latency", lat, TS + 2);
    check("press_level_same_cycle", int'(lvl_at), 0);
    @(negedge clk);
    check("press_width", int'(press_pulse), 0);
    apply(1'b0, 10, np, nr);
    apply(1'b1, 40, np, nr);
    check("release_before_reset", nr, 1);

    // reset in the middle of a press window (cnt = 8)
    in_sig = 1'b0;
    repeat (11) @(negedge clk);
    check("mid_filter_state", int'(dbg_state), int'(FILT_DN));
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_out", int'({dbg_state, key_level, press_pulse, release_pulse, bounce_cnt}),
          int'(pack(MODEL_RST)));
    repeat (2) @(negedge clk);
    check("rst_hold_out", int'({dbg_state, key_level, press_pulse, release_pulse, bounce_cnt}),
          int'(pack(MODEL_RST)));
    #2 rst_n = 1'b1;
    wait_press(lat, lvl_at);
    check("post_rst_latency", lat, TS + 2);
    apply(1'b0, 30, np, nr);
    check("post_rst_extra_press", np, 0);
    check("post_rst_bounce", int'(bounce_cnt), 1);

    // random phases against the model
    for (int i = 0; i < 80; i++)
      apply(logic'($urandom_range(0, 1)), $urandom_range(1, 22), np, nr);
    apply(1'b1, 40, np, nr);
    check("final_level", int'(key_level), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
